srl_tap_delay: RTL
==================

// Module: srl_tap_delay
// PURPOSE
//  Parametrised, clock-enabled shift-register delay line with a dynamic read tap and fill tracking.
//  The storage chain carries no reset and no per-stage keep, so it maps onto SRL16E/SRLC32E primitives.
//  Reset lives only in the fill counter and the output masking.
//  Sits between a sample source and a consumer that needs a run-time-selectable delay of 1..DEPTH cycles.
// PARAMETERS
//  WIDTH    8  data bits per stage
//  DEPTH    32 chain length in stages, 2..256; AW = $clog2(DEPTH)
//  CLK_NEG  0  1: all state updates on negedge clk; 0: on posedge clk
// PORTS
//  clk     in   1      clock; active edge selected by CLK_NEG
//  rst     in   1      asynchronous, active-high reset
//  ce      in   1      shift enable; chain and counter are frozen when low
//  d       in   WIDTH  sample shifted into stage 0 when ce=1
//  addr    in   AW     tap select; q = sample written addr+1 enabled shifts ago
//  q       out  WIDTH  tap data, forced to 0 when q_vld=0
//  q_vld   out  1      addr < fill, i.e. the tapped stage holds a written sample
//  q_last  out  WIDTH  stage DEPTH-1 (fixed tap), forced to 0 when full=0
//  fill    out  AW+1   count of written stages, saturates at DEPTH
//  full    out  1      fill == DEPTH
// BEHAVIOUR
//  - Storage: on the active edge with ce=1: sr[0]<=d, sr[k]<=sr[k-1] for k=1..DEPTH-1.
//    With ce=0 storage holds. Storage is not reset; its contents are undefined after power-up.
//  - Fill: async rst forces fill=0 immediately, so q_vld=0, full=0, q=0, q_last=0.
//    On the active edge with ce=1 and fill<DEPTH: fill<=fill+1. At fill==DEPTH it saturates and never wraps.
//  - Tap read is combinational from sr[addr] and q_vld: zero latency from addr change to q.
//    The write-to-read delay is addr+1 enabled edges.
//  - addr>=DEPTH (only when DEPTH is not a power of 2): q_vld=0, q=0; no X propagation.
//  - Simultaneous ce=1 and addr change: q reflects the new addr against the post-edge chain.
//  - rst asserted mid-stream: outputs go to 0 asynchronously and the chain keeps its stale data, masked.
//    After rst deasserts, fill restarts at 0; stale samples are never reported valid.
//  - rst deassertion is synchronised externally; no edge in the same cycle is required to update state.
//  - CLK_NEG=1 changes only the sampling edge; all relations above hold unchanged.
// CONFIGURATION
//  `SRL_TAP_OUT_REG_EN defined:
//   - Adds a reset-able output register stage for q, q_vld and q_last.
//   - The stage updates every active edge, independent of ce.
//   - Read latency becomes 1 clock: q(t+1) = masked sr[addr](t).
//   - rst clears the registered outputs to 0 asynchronously.
//   - Maps to SRL + FDCE/FDPE.
//  undefined:
//   - Combinational tap as above; SRL primitives plus fill logic only.
// STRUCTURE
//  - Package srl_tap_pkg:
//    - function clog2_min1 (AW, minimum 1)
//    - typedef fill_t (AW+1 bits)
//    - localparam MAX_DEPTH=256
//  - One sub-module, srl_tap_chain:
//    - single-bit, no-reset, ce-gated shift chain with a dynamic tap.
//    - Instantiated WIDTH times via generate.
//  - Top: fill counter, masking, optional output register.
// TESTING (WIDTH=8, DEPTH=32, combinational unless stated)
//  1 rst=1 then 0; ce=1; d=1,2,3,...; addr=4
//    -> q_vld=0 for edges 1..4; after edge 5 q=8'h01, then 2, 3...; fill counts 1..32 then holds 32, full=1.
//  2 Full chain; ce=0 for 10 clocks while d toggles
//    -> q, q_last, fill unchanged; resume ce=1 -> sequence continues without gap.
//  3 Full chain; sweep addr 0..31 with ce=0
//    -> q equals the samples written 1..32 shifts ago; q_last equals the addr=31 value.
//  4 Mid-stream rst pulse, asynchronous, 3 ns between edges
//    -> q=0, q_vld=0, fill=0 before the next edge; after release, first valid at addr=0 on edge 1.
//  5 DEPTH=20, addr=25
//    -> q_vld=0, q=0 even when full=1.
//  6 With SRL_TAP_OUT_REG_EN, CLK_NEG=1
//    -> the test 1 sequence appears one negedge later.
//    -> Synthesis: select t:SRL* count = 8, and no FDRE in the chain.

Source files
------------

// File: rtl/srl_tap_pkg.sv
// Shared types and helpers for the srl_tap_delay delay line.
package srl_tap_pkg;

  localparam int MAX_DEPTH = 256;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Wide enough for a fill count at the largest supported depth.
  typedef logic [clog2_min1(MAX_DEPTH):0] fill_t;

endpackage

// File: rtl/srl_tap_chain.sv
// Single-bit shift chain with a dynamic read tap and a fixed last-stage tap.
// No reset and no per-stage hold, so the chain can be packed into SRL primitives.
module srl_tap_chain #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          ce,
  input  logic          d,
  input  logic [AW-1:0] addr,
  output logic          q,
  output logic          q_last
);

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk)
    if (ce) sr <= {sr[DEPTH-2:0], d};

  // Out-of-range taps exist only for non-power-of-2 depths; return 0 instead of X.
  assign q      = ({1'b0, addr} < DEPTH_W) ? sr[addr] : 1'b0;
  assign q_last = sr[DEPTH-1];

endmodule

// File: rtl/srl_tap_delay.sv
// Clock-enabled delay line with run-time tap select and fill tracking.
// Optional registered outputs: define SRL_TAP_OUT_REG_EN.
module srl_tap_delay
  import srl_tap_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int DEPTH   = 32,
  parameter  bit CLK_NEG = 1'b0,
  localparam int AW      = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  output logic [WIDTH-1:0] q_last,
  output logic [AW:0]      fill,
  output logic             full
);

  localparam fill_t       DEPTH_F = fill_t'(DEPTH);
  localparam logic [AW:0] DEPTH_W = DEPTH_F[AW:0];

  // Edge selection is a plain clock inversion so it folds into the primitives' clock polarity.
  logic aclk;
  assign aclk = CLK_NEG ? ~clk : clk;

  logic [WIDTH-1:0] tap_raw, last_raw;

  genvar b;
  generate
    for (b = 0; b < WIDTH; b++) begin : g_bit
      srl_tap_chain #(.DEPTH(DEPTH), .AW(AW)) u_chain (
        .clk    (aclk),
        .ce     (ce),
        .d      (d[b]),
        .addr   (addr),
        .q      (tap_raw[b]),
        .q_last (last_raw[b])
      );
    end
  endgenerate

  logic [AW:0] fill_r;

  always_ff @(posedge aclk or posedge rst)
    if (rst)                         fill_r <= '0;
    else if (ce && fill_r != DEPTH_W) fill_r <= fill_r + 1'b1;

  logic             full_c, vld_c;
  logic [WIDTH-1:0] q_c, q_last_c;

  // Stale chain contents survive reset; the fill count is what keeps them hidden.
  assign full_c   = (fill_r == DEPTH_W);
  assign vld_c    = ({1'b0, addr} < fill_r);
  assign q_c      = vld_c  ? tap_raw  : '0;
  assign q_last_c = full_c ? last_raw : '0;

  assign fill = fill_r;
  assign full = full_c;

`ifdef SRL_TAP_OUT_REG_EN
  always_ff @(posedge aclk or posedge rst)
    if (rst) begin
      q      <= '0;
      q_vld  <= 1'b0;
      q_last <= '0;
    end else begin
      q      <= q_c;
      q_vld  <= vld_c;
      q_last <= q_last_c;
    end
`else
  assign q      = q_c;
  assign q_vld  = vld_c;
  assign q_last = q_last_c;
`endif

endmodule
